// File: rtl/vote_pkg.sv
// vote_pkg: shared state encoding and sizing constants for the voting session controller
package vote_pkg;
  typedef enum logic [1:0] {IDLE, OPEN, TALLY, HOLD} vote_state_t;
  localparam int N_VOTERS_DEF = 9;
  localparam int QUORUM_DEF   = 5;
  localparam int CNT_W        = 4;
endpackage

// File: rtl/vote_session_popcount.sv
// vote_popcount: counts set bits of an N-bit vector into a CNT_W-bit result
module vote_popcount
  import vote_pkg::*;
#(
  parameter int N = N_VOTERS_DEF
) (
  input  logic [N-1:0]     bits_i,
  output logic [CNT_W-1:0] count_o
);
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) count_o = count_o + CNT_W'(bits_i[i]);
  end
endmodule

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: opens a timed ballot window, records first ballots per voter,
// tallies majority/quorum and holds the result under a valid/ready handshake
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int N_VOTERS = N_VOTERS_DEF,
  parameter int QUORUM   = QUORUM_DEF,
  parameter int WIN_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WIN_W-1:0]    window_len,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_val,
  output logic                busy,
  output logic [N_VOTERS-1:0] cast_mask,
  output logic [CNT_W-1:0]    tally_yes,
  output logic [CNT_W-1:0]    tally_no,
  output logic                result,
  output logic                quorum_ok,
  output logic                result_valid,
  input  logic                result_ready
);
  vote_state_t         state_q, state_d;
  logic [WIN_W-1:0]    cnt_q, cnt_d;
  logic [N_VOTERS-1:0] mask_q, mask_d, ballot_q, ballot_d, accept;
  logic [CNT_W-1:0]    yes_q, yes_d, no_q, no_d, yes_cnt, no_cnt, cast_cnt;
  logic                result_q, result_d, quorum_q, quorum_d, valid_q, valid_d;

  vote_popcount #(.N(N_VOTERS)) u_yes  (.bits_i(ballot_q & mask_q),  .count_o(yes_cnt));
  vote_popcount #(.N(N_VOTERS)) u_no   (.bits_i(~ballot_q & mask_q), .count_o(no_cnt));
  vote_popcount #(.N(N_VOTERS)) u_cast (.bits_i(mask_q),             .count_o(cast_cnt));

  // only first strobes from voters not yet cast update the ballot register
  assign accept = vote_valid & ~mask_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    ballot_d = ballot_q;
    yes_d    = yes_q;
    no_d     = no_q;
    result_d = result_q;
    quorum_d = quorum_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = OPEN;
        cnt_d    = (window_len == '0) ? WIN_W'(1) : window_len;
        mask_d   = '0;
        ballot_d = '0;
      end
      OPEN: if (abort) begin
        state_d = IDLE;
        mask_d  = '0;
      end else begin
        mask_d   = mask_q | vote_valid;
        ballot_d = (ballot_q & ~accept) | (vote_val & accept);
        cnt_d    = cnt_q - WIN_W'(1);
        state_d  = (cnt_q == WIN_W'(1) || &(mask_q | vote_valid)) ? TALLY : OPEN;
      end
      TALLY: if (abort) begin
        state_d = IDLE;
        mask_d  = '0;
      end else begin
        yes_d    = yes_cnt;
        no_d     = no_cnt;
        result_d = yes_cnt > CNT_W'(N_VOTERS / 2);
        quorum_d = cast_cnt >= CNT_W'(QUORUM);
        valid_d  = 1'b1;
        state_d  = HOLD;
      end
      HOLD: if (valid_q && result_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      ballot_q <= '0;
      yes_q    <= '0;
      no_q     <= '0;
      result_q <= 1'b0;
      quorum_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      ballot_q <= ballot_d;
      yes_q    <= yes_d;
      no_q     <= no_d;
      result_q <= result_d;
      quorum_q <= quorum_d;
      valid_q  <= valid_d;
    end
  end

  assign busy         = state_q != IDLE;
  assign cast_mask    = mask_q;
  assign tally_yes    = yes_q;
  assign tally_no     = no_q;
  assign result       = result_q;
  assign quorum_ok    = quorum_q;
  assign result_valid = valid_q;
endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb_vote_session_ctrl: directed vectors with hand-computed expectations for vote_session_ctrl
module tb_vote_session_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] window_len = '0;
  logic [8:0]  vote_valid = '0;
  logic [8:0]  vote_val = '0;
  logic        result_ready = 1'b0;
  logic        busy, result, quorum_ok, result_valid;
  logic [8:0]  cast_mask;
  logic [3:0]  tally_yes, tally_no;
  int          n_vec = 0;
  int          n_err = 0;

  vote_session_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .window_len(window_len),
    .vote_valid(vote_valid), .vote_val(vote_val), .busy(busy), .cast_mask(cast_mask),
    .tally_yes(tally_yes), .tally_no(tally_no), .result(result), .quorum_ok(quorum_ok),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic open_session(input logic [15:0] wl);
    start = 1'b1;
    window_len = wl;
    tick();
    start = 1'b0;
  endtask

  task automatic cast(input logic [8:0] v, input logic [8:0] d);
    vote_valid = v;
    vote_val = d;
    tick();
    vote_valid = '0;
    vote_val = '0;
  endtask

  task automatic check_res(input string tag, input logic [3:0] y, input logic [3:0] n,
                           input logic r, input logic q, input logic v);
    check({tag, "_yes"}, 32'(tally_yes), 32'(y));
    check({tag, "_no"}, 32'(tally_no), 32'(n));
    check({tag, "_result"}, 32'(result), 32'(r));
    check({tag, "_quorum"}, 32'(quorum_ok), 32'(q));
    check({tag, "_valid"}, 32'(result_valid), 32'(v));
  endtask

  initial begin
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_mask", 32'(cast_mask), 0);
    check_res("rst", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    open_session(16'd20);
    check("t1_busy", 32'(busy), 1);
    tick();
    cast(9'h1FF, 9'h1F0);
    check("t1_mask", 32'(cast_mask), 32'h1FF);
    check("t1_early_valid", 32'(result_valid), 0);
    tick();
    check_res("t1", 5, 4, 1, 1, 1);
    result_ready = 1'b1;
    tick();
    check("t1_idle", 32'(busy), 0);
    check_res("t1_keep", 5, 4, 1, 1, 0);

    open_session(16'd4);
    cast(9'h00F, 9'h00F);
    tick(3);
    check("t2_tally_valid", 32'(result_valid), 0);
    check("t2_tally_busy", 32'(busy), 1);
    tick();
    check("t2_mask", 32'(cast_mask), 32'h00F);
    check_res("t2", 4, 0, 0, 0, 1);
    tick();
    check("t2_idle", 32'(busy), 0);
    result_ready = 1'b0;

    open_session(16'd3);
    cast(9'h004, 9'h004);
    cast(9'h007, 9'h000);
    tick(2);
    check("t3_mask", 32'(cast_mask), 32'h007);
    check_res("t3", 1, 2, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      tick();
      check("t3_hold_valid", 32'(result_valid), 1);
      check("t3_hold_yes", 32'(tally_yes), 1);
      check("t3_hold_busy", 32'(busy), 1);
    end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    check("t3_release_busy", 32'(busy), 0);
    check("t3_release_valid", 32'(result_valid), 0);
    result_ready = 1'b0;
    open_session(16'd2);
    check("t3_restart_busy", 32'(busy), 1);
    check("t3_restart_mask", 32'(cast_mask), 0);
    tick(3);
    check_res("t3_empty", 0, 0, 0, 0, 1);
    result_ready = 1'b1;
    tick();
    check("t3_empty_idle", 32'(busy), 0);
    result_ready = 1'b0;

    open_session(16'd10);
    cast(9'h01F, 9'h01F);
    check("t4_mask", 32'(cast_mask), 32'h01F);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_busy", 32'(busy), 0);
    check("t4_abort_mask", 32'(cast_mask), 0);
    tick(3);
    check_res("t4_abort", 0, 0, 0, 0, 0);

    open_session(16'd1);
    cast(9'h001, 9'h001);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_tabort_busy", 32'(busy), 0);
    check("t4_tabort_mask", 32'(cast_mask), 0);
    tick(2);
    check_res("t4_tabort", 0, 0, 0, 0, 0);

    open_session(16'd0);
    cast(9'h03F, 9'h03F);
    check("t5_w0_busy", 32'(busy), 1);
    check("t5_w0_valid", 32'(result_valid), 0);
    tick();
    check_res("t5_w0", 6, 0, 1, 1, 1);
    result_ready = 1'b1;
    tick();
    check("t5_idle", 32'(busy), 0);
    result_ready = 1'b0;

    open_session(16'd10);
    cast(9'h0FF, 9'h0FF);
    check("t6_mask", 32'(cast_mask), 32'h0FF);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_mask", 32'(cast_mask), 0);
    check_res("t6_rst", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    open_session(16'd1);
    cast(9'h1FF, 9'h000);
    tick();
    check_res("t6_after", 0, 9, 0, 1, 1);
    result_ready = 1'b1;
    tick();
    check("t6_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vote_session_ctrl.md
# vote_session_ctrl

Sequencing controller for the 9-voter majority datapath. It opens a timed voting window on `start` and accepts at most one ballot per voter, first ballot wins. When the window expires or all voters have cast, it tallies the ballots, computes majority and quorum, and holds the result under a valid/ready handshake. It sits between the voter input stage and the downstream result consumer.

## Interface
- `N_VOTERS`, default 9: number of voters; the tally is sized for it.
- `QUORUM`, default 5: minimum number of cast ballots for `quorum_ok`.
- `WIN_W`, default 16: width of the window-length counter.
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: request to open a session; honoured only in IDLE.
- `abort`, in, 1: cancel the session in OPEN or TALLY.
- `window_len`, in, WIN_W: window length in cycles; sampled with `start`; 0 is treated as 1.
- `vote_valid`, in, N_VOTERS: per-voter ballot strobe.
- `vote_val`, in, N_VOTERS: per-voter ballot value, 1 = agree.
- `busy`, out, 1: high in OPEN, TALLY and HOLD.
- `cast_mask`, out, N_VOTERS: registered; bit i set once voter i has cast.
- `tally_yes`, out, 4: count of agree ballots.
- `tally_no`, out, 4: count of disagree ballots.
- `result`, out, 1: high when `tally_yes` > N_VOTERS/2 (≥5 for 9), an absolute majority of all voters.
- `quorum_ok`, out, 1: high when popcount(`cast_mask`) ≥ QUORUM.
- `result_valid`, out, 1: result handshake valid.
- `result_ready`, in, 1: result handshake ready from the consumer.

## Operation
- States are IDLE, OPEN, TALLY and HOLD.
- **Reset:** state goes to IDLE. Every output and internal register is 0: `busy`, `cast_mask`, ballots, counter, `tally_yes`, `tally_no`, `result`, `quorum_ok`, `result_valid`.
- **IDLE:**
  - On `start`, load counter = max(`window_len`, 1), clear `cast_mask` and the ballot register, and go to OPEN.
  - `tally_yes`, `tally_no`, `result` and `quorum_ok` keep their previous values until the next TALLY.
- **OPEN:**
  - For each i with `vote_valid[i]` and `!cast_mask[i]`: ballot[i] ← `vote_val[i]` and `cast_mask[i]` ← 1.
  - A strobe from a voter who has already cast is ignored, even if it arrives in the same cycle as other voters' first ballots.
  - The counter decrements every OPEN cycle.
  - Go to TALLY when counter == 1 (last window cycle), or when the updated `cast_mask` is all ones (early close).
  - Ballots arriving in the closing cycle are accepted.
- **TALLY (one cycle):**
  - `tally_yes` = popcount(ballot & `cast_mask`).
  - `tally_no` = popcount(~ballot & `cast_mask`).
  - Compute `result` and `quorum_ok`, register all of them, set `result_valid`, and go to HOLD.
  - Voters who did not cast count as neither yes nor no.
- **HOLD:** outputs stay stable. When `result_valid` && `result_ready`, clear `result_valid` and go to IDLE.
- **`start` outside IDLE:** ignored in OPEN, TALLY and HOLD. It is not queued and must be reasserted in IDLE.
- **`abort`:**
  - In OPEN or TALLY: go to IDLE and clear `cast_mask`. No result is produced and the tally outputs are unchanged.
  - Ignored in IDLE and HOLD; a produced result is always delivered.
  - `abort` has priority over close and tally in the same cycle.
- **Width rule:** all counts are 4 bits, which is sufficient for N_VOTERS ≤ 15. The comparison is unsigned.

## Timing
- `start` sampled at edge E0 puts the block in OPEN from E0 onward, with `busy` = 1 after E0.
- With window W, ballots are sampled at edges E1..EW, and the block is in TALLY after EW.
- Tally outputs and `result_valid` = 1 are visible after E(W+1).
- Early close: if all voters have cast at edge Ek (k < W), TALLY follows after Ek and `result_valid` is visible after E(k+1).
- If `result_ready` is already high when `result_valid` rises, the handshake completes at the next edge and `busy` = 0 after it. The minimum HOLD duration is one cycle.
- `rst_n` asserted mid-session forces IDLE and zeros all outputs immediately, without waiting for a clock edge.

## Structure
- Package `vote_pkg` holds:
  - the state enum `vote_state_t` (IDLE, OPEN, TALLY, HOLD);
  - constants `N_VOTERS_DEF` = 9, `QUORUM_DEF` = 5 and `CNT_W` = 4.
- One sub-module, `vote_popcount` (N_VOTERS-bit to 4-bit count), is instantiated three times: yes, no and cast counts.
- The FSM, window counter and ballot/mask registers live in `vote_session_ctrl`.

## Test plan
- **Full early close:** `start` with `window_len` = 20; all 9 voters strobe at E2 with `vote_val` = 9'b1_1111_0000 → TALLY after E2; after E3 `tally_yes` = 5, `tally_no` = 4, `result` = 1, `quorum_ok` = 1, `result_valid` = 1.
- **Timeout with partial votes:** `window_len` = 4; voters 0–3 cast yes → after E5 `cast_mask` = 9'h00F, `tally_yes` = 4, `result` = 0, `quorum_ok` = 0.
- **Duplicate ballots:** voter 2 casts 1 at E1 and 0 at E2 → ballot stays 1; `tally_yes` includes voter 2 exactly once.
- **Handshake and ignored start:** hold `result_ready` = 0 for 5 cycles while pulsing `start` → `result_valid` stays 1 and outputs are stable; raise ready → IDLE next edge; `start` is then accepted.
- **Abort and `window_len` = 0:** `abort` during OPEN → IDLE next edge, `cast_mask` = 0, `result_valid` never rises; a session with `window_len` = 0 runs 1 OPEN cycle and produces a result after E2.
- **Async reset mid-OPEN:** drop `rst_n` mid-cycle → all outputs 0 immediately; after release, IDLE and a new `start` behaves normally.
